// File: rtl/game_ctrl.sv
// rtl/game_ctrl.sv - game sequencing: start, flap, physics tick, death timer, score/hiscore
module game_ctrl #(
    parameter int PHYS_DIV     = 2,
    parameter int DEATH_FRAMES = 60,
    parameter int SCORE_MAX    = 999
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ani_stb,
    input  logic       i_btn,
    input  logic       i_collide,
    input  logic       i_pipe_pass,
    output logic       o_flap,
    output logic       o_physics_stb,
    output logic       o_bird_rst,
    output logic [1:0] o_state,
    output logic [9:0] o_score,
    output logic [9:0] o_hiscore
);

    localparam int DIV_W = (PHYS_DIV > 1) ? $clog2(PHYS_DIV) : 1;
    localparam int FRM_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(PHYS_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_LAST  = FRM_W'(DEATH_FRAMES - 1);
    localparam logic [9:0]       SCORE_SAT = 10'(SCORE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_btn_q;
    logic               w_btn_edge;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [FRM_W-1:0]   r_frm;
    logic [FRM_W-1:0]   w_frm_nxt;
    logic [9:0]         r_score;
    logic [9:0]         w_score_nxt;
    logic [9:0]         r_hiscore;
    logic [9:0]         w_hiscore_nxt;
    logic               r_flap;
    logic               w_flap_nxt;
    logic               r_phys;
    logic               w_phys_nxt;
    logic               r_bird_rst;

    assign w_btn_edge = i_btn & ~r_btn_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_flap_nxt    = 1'b0;
        w_phys_nxt    = 1'b0;
        w_div_nxt     = r_div;
        w_frm_nxt     = r_frm;
        w_score_nxt   = r_score;
        w_hiscore_nxt = r_hiscore;

        // The bird keeps falling while dying, so the divider runs in both active states.
        if ((r_state == S_PLAY || r_state == S_DYING) && i_ani_stb) begin
            w_phys_nxt = (r_div == DIV_LAST);
            w_div_nxt  = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_div_nxt = '0;
                w_frm_nxt = '0;
                if (w_btn_edge) begin
                    w_state_nxt = S_PLAY;
                    w_flap_nxt  = 1'b1;
                    w_score_nxt = '0;
                end
            end
            S_PLAY: begin
                w_frm_nxt = '0;
                if (i_pipe_pass && (r_score < SCORE_SAT)) begin
                    w_score_nxt = r_score + 10'd1;
                end
                // A collision wins over a flap pressed in the same cycle.
                if (i_collide) begin
                    w_state_nxt = S_DYING;
                end else if (w_btn_edge) begin
                    w_flap_nxt = 1'b1;
                end
            end
            S_DYING: begin
                if (i_ani_stb) begin
                    if (r_frm == FRM_LAST) begin
                        w_state_nxt   = S_OVER;
                        w_frm_nxt     = '0;
                        w_div_nxt     = '0;
                        w_hiscore_nxt = (r_score > r_hiscore) ? r_score : r_hiscore;
                    end else begin
                        w_frm_nxt = r_frm + 1'b1;
                    end
                end
            end
            S_OVER: begin
                w_div_nxt = '0;
                w_frm_nxt = '0;
                if (w_btn_edge) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // btn_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_btn_q    <= 1'b1;
            r_div      <= '0;
            r_frm      <= '0;
            r_score    <= '0;
            r_hiscore  <= '0;
            r_flap     <= 1'b0;
            r_phys     <= 1'b0;
            r_bird_rst <= 1'b1;
        end else begin
            r_btn_q    <= i_btn;
            r_div      <= w_div_nxt;
            r_frm      <= w_frm_nxt;
            r_score    <= w_score_nxt;
            r_hiscore  <= w_hiscore_nxt;
            r_flap     <= w_flap_nxt;
            r_phys     <= w_phys_nxt;
            r_bird_rst <= (w_state_nxt == S_IDLE);
        end
    end

    assign o_flap        = r_flap;
    assign o_physics_stb = r_phys;
    assign o_bird_rst    = r_bird_rst;
    assign o_state       = r_state;
    assign o_score       = r_score;
    assign o_hiscore     = r_hiscore;

endmodule

// File: tb/tb_game_ctrl.sv
// tb/tb_game_ctrl.sv - scoreboard bench for game_ctrl against a rule-level reference model
module tb_game_ctrl;

    localparam int PHYS_DIV     = 2;
    localparam int DEATH_FRAMES = 60;
    localparam int SCORE_MAX    = 999;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_ani_stb = 1'b0;
    logic       i_btn = 1'b1;
    logic       i_collide = 1'b0;
    logic       i_pipe_pass = 1'b0;
    logic       o_flap;
    logic       o_physics_stb;
    logic       o_bird_rst;
    logic [1:0] o_state;
    logic [9:0] o_score;
    logic [9:0] o_hiscore;

    game_ctrl #(
        .PHYS_DIV(PHYS_DIV),
        .DEATH_FRAMES(DEATH_FRAMES),
        .SCORE_MAX(SCORE_MAX)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_ani_stb(i_ani_stb),
        .i_btn(i_btn),
        .i_collide(i_collide),
        .i_pipe_pass(i_pipe_pass),
        .o_flap(o_flap),
        .o_physics_stb(o_physics_stb),
        .o_bird_rst(o_bird_rst),
        .o_state(o_state),
        .o_score(o_score),
        .o_hiscore(o_hiscore)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0] st;
        logic       flap;
        logic       phys;
        logic       bird;
        logic [9:0] score;
        logic [9:0] hi;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    // Reference model: game mode 0..3, score counters and strobe tallies as plain integers.
    int   m_mode = 0;
    int   m_score = 0;
    int   m_hi = 0;
    int   m_phys_cnt = 0;
    int   m_death_cnt = 0;
    bit   m_btn_q = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit btn, input bit stb, input bit col, input bit pass, input bit rst);
        exp_t e;
        bit   edge_v;
        int   prev;
        e = '0;
        if (rst) begin
            m_mode = 0; m_score = 0; m_hi = 0;
            m_phys_cnt = 0; m_death_cnt = 0; m_btn_q = 1'b1;
        end else begin
            edge_v  = btn && !m_btn_q;
            m_btn_q = btn;
            prev    = m_mode;
            if ((prev == 1 || prev == 2) && stb) begin
                m_phys_cnt++;
                e.phys = ((m_phys_cnt % PHYS_DIV) == 0);
            end
            if (prev == 0) begin
                if (edge_v) begin
                    m_mode = 1; e.flap = 1'b1; m_score = 0; m_phys_cnt = 0;
                end
            end else if (prev == 1) begin
                if (pass) m_score = (m_score + 1 > SCORE_MAX) ? SCORE_MAX : m_score + 1;
                if (col) begin
                    m_mode = 2; m_death_cnt = 0;
                end else if (edge_v) begin
                    e.flap = 1'b1;
                end
            end else if (prev == 2) begin
                if (stb) begin
                    m_death_cnt++;
                    if (m_death_cnt == DEATH_FRAMES) begin
                        m_mode = 3;
                        if (m_score > m_hi) m_hi = m_score;
                    end
                end
            end else if (edge_v) begin
                m_mode = 0;
            end
        end
        e.st    = 2'(m_mode);
        e.bird  = (m_mode == 0);
        e.score = 10'(m_score);
        e.hi    = 10'(m_hi);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input bit btn, input bit stb, input bit col, input bit pass, input bit rst);
        @(negedge i_clk);
        i_btn = btn; i_ani_stb = stb; i_collide = col; i_pipe_pass = pass; i_rst = rst;
        model_step(btn, stb, col, pass, rst);
    endtask

    task automatic after_edge();
        @(posedge i_clk);
        #1;
    endtask

    always @(posedge i_clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sb_state", int'(o_state), int'(mon_e.st));
            chk("sb_flap", int'(o_flap), int'(mon_e.flap));
            chk("sb_physics_stb", int'(o_physics_stb), int'(mon_e.phys));
            chk("sb_bird_rst", int'(o_bird_rst), int'(mon_e.bird));
            chk("sb_score", int'(o_score), int'(mon_e.score));
            chk("sb_hiscore", int'(o_hiscore), int'(mon_e.hi));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit rb;

        // Button held through reset must not start a game.
        repeat (3) cyc(1, 0, 0, 0, 1);
        after_edge();
        chk("rst_state", int'(o_state), 0);
        chk("rst_bird_rst", int'(o_bird_rst), 1);
        repeat (5) cyc(1, 0, 0, 0, 0);
        after_edge();
        chk("held_btn_idle", int'(o_state), 0);

        repeat (2) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        after_edge();
        chk("start_state", int'(o_state), 1);
        chk("start_flap", int'(o_flap), 1);
        chk("start_bird_rst", int'(o_bird_rst), 0);
        cyc(1, 0, 0, 0, 0);
        after_edge();
        chk("start_flap_one_cycle", int'(o_flap), 0);

        // Strobe every 8 cycles with random flaps.
        for (int k = 0; k < 48; k++) cyc($urandom_range(0, 1) == 1, (k % 8) == 0, 0, 0, 0);

        // Score saturation.
        for (int k = 0; k < 1001; k++) begin
            cyc(0, 0, 0, 1, 0);
            cyc(0, 0, 0, 0, 0);
        end
        after_edge();
        chk("score_saturated", int'(o_score), SCORE_MAX);

        // Collision together with a button edge: no flap.
        cyc(1, 0, 1, 0, 0);
        after_edge();
        chk("collide_btn_state", int'(o_state), 2);
        chk("collide_btn_no_flap", int'(o_flap), 0);
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < DEATH_FRAMES; k++) begin
            cyc(k % 2 == 1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
            repeat (3) cyc(0, 0, 0, 0, 0);
        end
        after_edge();
        chk("over_state", int'(o_state), 3);
        chk("over_hiscore", int'(o_hiscore), SCORE_MAX);
        cyc(1, 0, 0, 0, 0);
        after_edge();
        chk("over_to_idle", int'(o_state), 0);
        chk("idle_score_kept", int'(o_score), SCORE_MAX);

        // Score 5, then collide and pass together.
        repeat (2) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        after_edge();
        chk("collide_pass_score", int'(o_score), 6);
        chk("collide_pass_state", int'(o_state), 2);
        for (int k = 0; k < DEATH_FRAMES; k++) begin
            cyc(k % 2 == 1, 1, 0, 0, 0);
            cyc(0, 0, 0, 0, 0);
        end
        after_edge();
        chk("dying_over_state", int'(o_state), 3);
        chk("dying_over_hiscore", int'(o_hiscore), 6);

        // Reset in DYING with score 7.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 0, 0);
        after_edge();
        chk("pre_rst_score", int'(o_score), 7);
        repeat (3) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 1, 1);
        after_edge();
        chk("mid_rst_state", int'(o_state), 0);
        chk("mid_rst_score", int'(o_score), 0);
        chk("mid_rst_hiscore", int'(o_hiscore), 0);
        chk("mid_rst_bird_rst", int'(o_bird_rst), 1);

        // Random play.
        rb = 1'b1;
        for (int k = 0; k < 6000; k++) begin
            if ($urandom_range(0, 5) == 0) rb = ~rb;
            cyc(rb, $urandom_range(0, 2) == 0, $urandom_range(0, 59) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 799) == 0);
        end

        repeat (2) @(posedge i_clk);
        #2;
        chk("sb_drain", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
